// File: rtl/lifo_stack.sv
// lifo_stack: 3-cycle trigger/done LIFO over a synchronous single-port RAM.
// Optional overflow/underflow protection with sticky err: define LIFO_STACK_ERR_EN.
// Without it the stack pointer wraps and err stays 0.
module lifo_stack #(
    parameter int STACKDATA = 32,
    parameter int STACKSIZE = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         trigger,
    input  logic [STACKDATA-1:0]         write_value,
    output logic [STACKDATA-1:0]         read_value,
    output logic                         done_out,
    output logic [$clog2(STACKSIZE):0]   depth,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);
    localparam int AW = $clog2(STACKSIZE);
    localparam logic [AW:0] SP_FULL = (AW+1)'(STACKSIZE);
    localparam logic [AW:0] SP_TOP = (AW+1)'(STACKSIZE - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW:0]            sp_q, sp_d;
    logic                   op_push_q, op_push_d;
    logic [STACKDATA-1:0]   wdata_q, wdata_d;
    logic [STACKDATA-1:0]   read_value_q;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   mem_we, mem_re, blocked;
    logic [AW-1:0]          addr;
    logic [STACKDATA-1:0]   mem [STACKSIZE];

    assign full  = sp_q == SP_FULL;
    assign empty = sp_q == '0;
    assign depth = sp_q;
    assign read_value = read_value_q;
    assign done_out = done_q;
    assign err = err_q;
    assign addr = op_push_q ? sp_q[AW-1:0] : sp_q[AW-1:0] - AW'(1);
`ifdef LIFO_STACK_ERR_EN
    assign blocked = op_push_q ? full : empty;
`else
    assign blocked = 1'b0;
`endif

    // Next-state: latch the request in IDLE, perform the RAM access in EXEC.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        op_push_d = op_push_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            IDLE: if (trigger) begin
                op_push_d = push;
                wdata_d   = write_value;
                state_d   = EXEC;
            end
            EXEC: begin
                done_d  = 1'b1;
                state_d = DONE;
                if (blocked) err_d = 1'b1;
                else if (op_push_q) begin
                    mem_we = 1'b1;
                    sp_d   = full ? '0 : sp_q + (AW+1)'(1);
                end else begin
                    mem_re = 1'b1;
                    sp_d   = empty ? SP_TOP : sp_q - (AW+1)'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage array is never reset; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (mem_we) mem[addr] <= wdata_q;
    end

    // Control and output registers; the RAM read lands directly in read_value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sp_q         <= '0;
            op_push_q    <= 1'b0;
            wdata_q      <= '0;
            read_value_q <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            op_push_q <= op_push_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            if (mem_re) read_value_q <= mem[addr];
        end
    end
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed scoreboard bench for lifo_stack with STACKSIZE=4.
module tb_lifo_stack;
    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst, push, trigger;
    logic [W-1:0] write_value, read_value;
    logic         done_out, empty, full, err;
    logic [2:0]   depth;

    typedef struct {
        logic [W-1:0] rv;
        int           dep;
        logic         er;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    lifo_stack #(.STACKDATA(W), .STACKSIZE(N)) dut (
        .clk(clk), .rst(rst), .push(push), .trigger(trigger),
        .write_value(write_value), .read_value(read_value), .done_out(done_out),
        .depth(depth), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every completion pulse consumes one expected response.
    always @(negedge clk) begin
        if (!rst && done_out) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done_out=1 expected no operation at %0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("read_value", 64'(read_value), 64'(mon_e.rv));
                chk("depth", 64'(depth), 64'(mon_e.dep));
                chk("err", 64'(err), 64'(mon_e.er));
                chk("empty", 64'(empty), 64'(mon_e.dep == 0));
                chk("full", 64'(full), 64'(mon_e.dep == N));
            end
        end
    end

    // Issue one operation from a negedge; hold re-pulses trigger during EXEC and DONE.
    task automatic op(input logic p, input logic [W-1:0] wv, input logic [W-1:0] erv,
                      input int edep, input logic eer, input logic hold);
        sbq.push_back('{erv, edep, eer});
        push = p;
        write_value = wv;
        trigger = 1'b1;
        @(negedge clk);
        trigger = hold;
        push = ~p;
        write_value = ~wv;
        chk("done_early", 64'(done_out), 64'd0);
        @(negedge clk);
        trigger = hold;
        chk("done_pulse", 64'(done_out), 64'd1);
        @(negedge clk);
        trigger = 1'b0;
        chk("done_clear", 64'(done_out), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b1;
        trigger = 1'b1;
        write_value = '1;
        repeat (3) @(negedge clk);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_read_value", 64'(read_value), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        trigger = 1'b0;
        @(negedge clk);

        op(1, 32'hDEADBEEF, 32'h0, 1, 0, 0);
        op(0, 32'h0, 32'hDEADBEEF, 0, 0, 0);

        op(1, 32'h11, 32'hDEADBEEF, 1, 0, 0);
        op(1, 32'h22, 32'hDEADBEEF, 2, 0, 0);
        op(0, 32'h0, 32'h22, 1, 0, 0);
        op(0, 32'h0, 32'h11, 0, 0, 0);

        op(1, 32'h33, 32'h11, 1, 0, 1);
        @(negedge clk);
        chk("hold_depth", 64'(depth), 64'd1);
        chk("hold_single_op", 64'(sbq.size()), 64'd0);
        op(0, 32'h0, 32'h33, 0, 0, 0);

        op(1, 32'd1, 32'h33, 1, 0, 0);
        op(1, 32'd2, 32'h33, 2, 0, 0);
        op(1, 32'd3, 32'h33, 3, 0, 0);
        op(1, 32'd4, 32'h33, 4, 0, 0);
`ifdef LIFO_STACK_ERR_EN
        op(1, 32'd5, 32'h33, 4, 1, 0);
        op(0, 32'h0, 32'd4, 3, 1, 0);
        op(0, 32'h0, 32'd3, 2, 1, 0);
        op(0, 32'h0, 32'd2, 1, 1, 0);
        op(0, 32'h0, 32'd1, 0, 1, 0);
        op(0, 32'h0, 32'd1, 0, 1, 0);
`else
        op(1, 32'd5, 32'h33, 0, 0, 0);
        op(0, 32'h0, 32'd4, 3, 0, 0);
        op(0, 32'h0, 32'd3, 2, 0, 0);
        op(0, 32'h0, 32'd2, 1, 0, 0);
        op(0, 32'h0, 32'd5, 0, 0, 0);
        op(0, 32'h0, 32'd4, 3, 0, 0);
`endif

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push = 1'b1;
        write_value = 32'h77;
        trigger = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done_out), 64'd0);
        end
        chk("abort_depth", 64'(depth), 64'd0);
        chk("abort_read_value", 64'(read_value), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        rst = 1'b0;
        trigger = 1'b0;
        @(negedge clk);
        chk("post_abort_depth", 64'(depth), 64'd0);
        op(1, 32'h99, 32'h0, 1, 0, 0);
        op(0, 32'h0, 32'h99, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
